// File: rtl/unified_memory_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : unified_memory_lsu_if
// Brief    : Fetch and data-port bundle for the unified memory / load-store unit.
// Revision : 1.0  initial release
// ============================================================================
interface unified_memory_lsu_if #(
   parameter int ADDR_W = 12
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_valid;

   logic              d_req_valid;
   logic              d_req_ready;
   logic              d_req_we;
   logic [1:0]        d_req_size;
   logic              d_req_unsigned;
   logic [ADDR_W-1:0] d_req_addr;
   logic [31:0]       d_req_wdata;
   logic              d_rsp_valid;
   logic [31:0]       d_rsp_rdata;
   logic              d_rsp_fault;

   modport master (
      output if_req, if_addr,
      output d_req_valid, d_req_we, d_req_size, d_req_unsigned, d_req_addr, d_req_wdata,
      input  if_rdata, if_valid,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_fault
   );

   modport slave (
      input  if_req, if_addr,
      input  d_req_valid, d_req_we, d_req_size, d_req_unsigned, d_req_addr, d_req_wdata,
      output if_rdata, if_valid,
      output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_fault
   );
endinterface
`default_nettype wire

// File: rtl/unified_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : unified_memory_lsu
// Brief    : Word-organised code/data memory with fetch port and byte/half/word LSU.
// Revision : 1.0  initial release
// ============================================================================
module unified_memory_lsu #(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = ""
) (
   input wire logic             clk,
   input wire logic             rst_n,
   unified_memory_lsu_if.slave  bus
);
   localparam int ADDR_W      = $clog2(DEPTH_WORDS) + 2;
   localparam int c_CNT_W     = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
   localparam int c_WAIT_INIT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   logic [31:0]        r_mem [DEPTH_WORDS];
   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [31:0]        r_ld_hold;
   logic               r_rsp_valid;
   logic [31:0]        r_rsp_rdata;
   logic               r_rsp_fault;
   logic               r_if_valid;
   logic [31:0]        r_if_rdata;

   logic [ADDR_W-3:0]  w_d_idx;
   logic [ADDR_W-3:0]  w_if_idx;
   logic [1:0]         w_lane;
   logic               w_ready;
   logic               w_accept;
   logic               w_fault;
   logic               w_wr_en;
   logic [3:0]         w_mask;
   logic [31:0]        w_wdata_rep;
   logic [31:0]        w_rd_word;
   logic [31:0]        w_shifted;
   logic [31:0]        w_ld_ext;
   logic               w_unused_ok;

   assign w_d_idx     = bus.d_req_addr[ADDR_W-1:2];
   assign w_if_idx    = bus.if_addr[ADDR_W-1:2];
   assign w_lane      = bus.d_req_addr[1:0];
   assign w_unused_ok = &{1'b0, bus.if_addr[1:0]};

   assign w_ready  = (r_state == S_IDLE) & rst_n;
   assign w_accept = bus.d_req_valid & w_ready;
   assign w_fault  = ((bus.d_req_size == 2'b01) & w_lane[0])
                   | ((bus.d_req_size == 2'b10) & (w_lane != 2'b00))
                   |  (bus.d_req_size == 2'b11);
   assign w_wr_en  = w_accept & bus.d_req_we & ~w_fault;

   // Store data is right-aligned on the bus; replicate it so every lane sees it.
   always_comb begin
      w_mask      = 4'b1111;
      w_wdata_rep = bus.d_req_wdata;
      case (bus.d_req_size)
         2'b00: begin
            w_mask      = 4'b0001 << w_lane;
            w_wdata_rep = {4{bus.d_req_wdata[7:0]}};
         end
         2'b01: begin
            w_mask      = 4'b0011 << w_lane;
            w_wdata_rep = {2{bus.d_req_wdata[15:0]}};
         end
         default: begin
            w_mask      = 4'b1111;
            w_wdata_rep = bus.d_req_wdata;
         end
      endcase
   end

   assign w_rd_word = r_mem[w_d_idx];
   assign w_shifted = w_rd_word >> {w_lane, 3'b000};

   always_comb begin
      w_ld_ext = w_rd_word;
      case (bus.d_req_size)
         2'b00:   w_ld_ext = bus.d_req_unsigned ? {24'd0, w_shifted[7:0]}
                                                : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_ld_ext = bus.d_req_unsigned ? {16'd0, w_shifted[15:0]}
                                                : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_ld_ext = w_rd_word;
      endcase
   end

   // Memory contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_mask[i]) begin
               r_mem[w_d_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_valid <= 1'b0;
         r_if_rdata <= 32'd0;
      end else begin
         r_if_valid <= bus.if_req;
         if (bus.if_req) begin
            r_if_rdata <= r_mem[w_if_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ld_hold   <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_fault <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_fault) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_fault <= 1'b1;
                     r_rsp_rdata <= 32'd0;
                  end else if (bus.d_req_we) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_fault <= 1'b0;
                     r_rsp_rdata <= 32'd0;
                  end else if (READ_LATENCY == 1) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_fault <= 1'b0;
                     r_rsp_rdata <= w_ld_ext;
                  end else begin
                     r_state   <= S_WAIT;
                     r_cnt     <= c_CNT_W'(c_WAIT_INIT);
                     r_ld_hold <= w_ld_ext;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_fault <= 1'b0;
                  r_rsp_rdata <= r_ld_hold;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_rsp_fault <= 1'b0;
               r_rsp_rdata <= 32'd0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.d_req_ready = w_ready;
   assign bus.d_rsp_valid = r_rsp_valid;
   assign bus.d_rsp_rdata = r_rsp_rdata;
   assign bus.d_rsp_fault = r_rsp_fault;
   assign bus.if_valid    = r_if_valid;
   assign bus.if_rdata    = r_if_rdata;
endmodule
`default_nettype wire

// File: tb/tb_unified_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_memory_lsu
// Brief    : Self-checking bench for unified_memory_lsu (latency 1 and latency 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_unified_memory_lsu;
   localparam int DEPTH = 64;
   localparam int AW    = 8;
   localparam int NV    = 29;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   unified_memory_lsu_if #(.ADDR_W(AW)) bus1 ();
   unified_memory_lsu_if #(.ADDR_W(AW)) bus4 ();

   unified_memory_lsu #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .INIT_FILE("")) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );
   unified_memory_lsu #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(4), .INIT_FILE("")) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4)
   );

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
   } vec_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } rsp_t;

   vec_t vecs [NV];
   rsp_t sb1 [$];
   rsp_t sb4 [$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [7:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_fault);
      vec_t v;
      v = '{we, size, uns, addr, wdata, exp_rdata, exp_fault};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   // Latency-1 port: one request, response expected on the very next cycle.
   task automatic req1(input vec_t v, input string name);
      rsp_t e;
      int   n;
      check({name, " ready"}, 32'(bus1.d_req_ready), 32'd1);
      bus1.d_req_valid    = 1'b1;
      bus1.d_req_we       = v.we;
      bus1.d_req_size     = v.size;
      bus1.d_req_unsigned = v.uns;
      bus1.d_req_addr     = v.addr;
      bus1.d_req_wdata    = v.wdata;
      sb1.push_back('{v.exp_rdata, v.exp_fault});
      @(negedge clk);
      bus1.d_req_valid = 1'b0;
      n = 1;
      while (!bus1.d_rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      e = sb1.pop_front();
      check({name, " latency"}, 32'(n), 32'd1);
      check({name, " rdata"}, bus1.d_rsp_rdata, e.rdata);
      check({name, " fault"}, 32'(bus1.d_rsp_fault), 32'(e.fault));
      @(negedge clk);
      check({name, " strobe"}, {bus1.d_rsp_valid, bus1.d_rsp_fault, bus1.d_rsp_rdata[29:0]}, 32'd0);
   endtask

   // Latency-4 port: valid/ready checked on every cycle of the transaction.
   task automatic req4(input vec_t v, input int lat, input string name);
      rsp_t e;
      bus4.d_req_valid    = 1'b1;
      bus4.d_req_we       = v.we;
      bus4.d_req_size     = v.size;
      bus4.d_req_unsigned = v.uns;
      bus4.d_req_addr     = v.addr;
      bus4.d_req_wdata    = v.wdata;
      sb4.push_back('{v.exp_rdata, v.exp_fault});
      @(negedge clk);
      bus4.d_req_valid = 1'b0;
      for (int k = 1; k <= lat + 1; k++) begin
         check($sformatf("%s k%0d valid", name, k), 32'(bus4.d_rsp_valid), 32'(k == lat));
         check($sformatf("%s k%0d ready", name, k), 32'(bus4.d_req_ready), 32'(k == lat + 1));
         if (k == lat) begin
            e = sb4.pop_front();
            check({name, " rdata"}, bus4.d_rsp_rdata, e.rdata);
            check({name, " fault"}, 32'(bus4.d_rsp_fault), 32'(e.fault));
         end
         if (k <= lat) @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1, 2'b10, 0, 8'h00, 32'h00000000, 32'h00000000, 0);
      vecs[1]  = mk(1, 2'b10, 0, 8'h04, 32'h00000000, 32'h00000000, 0);
      vecs[2]  = mk(1, 2'b10, 0, 8'h08, 32'h00000000, 32'h00000000, 0);
      vecs[3]  = mk(1, 2'b10, 0, 8'h10, 32'h11223344, 32'h00000000, 0);
      vecs[4]  = mk(1, 2'b00, 0, 8'h06, 32'h123456A5, 32'h00000000, 0);
      vecs[5]  = mk(0, 2'b10, 0, 8'h04, 32'h0,        32'h00A50000, 0);
      vecs[6]  = mk(0, 2'b00, 0, 8'h06, 32'h0,        32'hFFFFFFA5, 0);
      vecs[7]  = mk(0, 2'b00, 1, 8'h06, 32'h0,        32'h000000A5, 0);
      vecs[8]  = mk(1, 2'b01, 0, 8'h0A, 32'hFFFF8001, 32'h00000000, 0);
      vecs[9]  = mk(0, 2'b01, 0, 8'h0A, 32'h0,        32'hFFFF8001, 0);
      vecs[10] = mk(0, 2'b01, 1, 8'h0A, 32'h0,        32'h00008001, 0);
      vecs[11] = mk(0, 2'b00, 1, 8'h08, 32'h0,        32'h00000000, 0);
      vecs[12] = mk(0, 2'b00, 1, 8'h09, 32'h0,        32'h00000000, 0);
      vecs[13] = mk(0, 2'b10, 0, 8'h02, 32'h0,        32'h00000000, 1);
      vecs[14] = mk(1, 2'b01, 0, 8'h03, 32'h0000BEEF, 32'h00000000, 1);
      vecs[15] = mk(1, 2'b11, 0, 8'h00, 32'hFFFFFFFF, 32'h00000000, 1);
      vecs[16] = mk(0, 2'b11, 0, 8'h04, 32'h0,        32'h00000000, 1);
      vecs[17] = mk(0, 2'b10, 0, 8'h00, 32'h0,        32'h00000000, 0);
      vecs[18] = mk(0, 2'b10, 0, 8'h08, 32'h0,        32'h80010000, 0);
      vecs[19] = mk(1, 2'b00, 0, 8'h05, 32'h0000007F, 32'h00000000, 0);
      vecs[20] = mk(0, 2'b01, 0, 8'h04, 32'h0,        32'h00007F00, 0);
      vecs[21] = mk(0, 2'b00, 0, 8'h05, 32'h0,        32'h0000007F, 0);
      vecs[22] = mk(1, 2'b01, 0, 8'h00, 32'h0000FEDC, 32'h00000000, 0);
      vecs[23] = mk(0, 2'b01, 0, 8'h00, 32'h0,        32'hFFFFFEDC, 0);
      vecs[24] = mk(0, 2'b10, 0, 8'h00, 32'h0,        32'h0000FEDC, 0);
      vecs[25] = mk(1, 2'b10, 0, 8'h0C, 32'hCAFEF00D, 32'h00000000, 0);
      vecs[26] = mk(0, 2'b10, 0, 8'h0C, 32'h0,        32'hCAFEF00D, 0);
      vecs[27] = mk(0, 2'b00, 0, 8'h0F, 32'h0,        32'hFFFFFFCA, 0);
      vecs[28] = mk(0, 2'b01, 1, 8'h0E, 32'h0,        32'h0000CAFE, 0);

      bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req_valid = 1'b0; bus1.d_req_we = 1'b0;
      bus1.d_req_size = 2'b00; bus1.d_req_unsigned = 1'b0; bus1.d_req_addr = '0; bus1.d_req_wdata = '0;
      bus4.if_req = 1'b0; bus4.if_addr = '0; bus4.d_req_valid = 1'b0; bus4.d_req_we = 1'b0;
      bus4.d_req_size = 2'b00; bus4.d_req_unsigned = 1'b0; bus4.d_req_addr = '0; bus4.d_req_wdata = '0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst if_valid", 32'(bus1.if_valid), 32'd0);
      check("rst if_rdata", bus1.if_rdata, 32'd0);
      check("rst rsp_valid", 32'(bus1.d_rsp_valid), 32'd0);
      check("rst rsp_rdata", bus1.d_rsp_rdata, 32'd0);
      check("rst ready1", 32'(bus1.d_req_ready), 32'd0);
      check("rst ready4", 32'(bus4.d_req_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rel ready1", 32'(bus1.d_req_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         req1(vecs[i], $sformatf("v%0d", i));
      end

      // Store and fetch hit word 0x10 on the same edge: fetch sees the old word.
      bus1.d_req_valid = 1'b1; bus1.d_req_we = 1'b1; bus1.d_req_size = 2'b10;
      bus1.d_req_unsigned = 1'b0; bus1.d_req_addr = 8'h10; bus1.d_req_wdata = 32'hDEADBEEF;
      bus1.if_req = 1'b1; bus1.if_addr = 8'h10;
      @(negedge clk);
      bus1.d_req_valid = 1'b0;
      bus1.if_addr = 8'h13;
      check("fetch old valid", 32'(bus1.if_valid), 32'd1);
      check("fetch old rdata", bus1.if_rdata, 32'h11223344);
      check("sw rsp_valid", 32'(bus1.d_rsp_valid), 32'd1);
      check("sw rsp_fault", 32'(bus1.d_rsp_fault), 32'd0);
      @(negedge clk);
      check("fetch new rdata", bus1.if_rdata, 32'hDEADBEEF);
      check("fetch new valid", 32'(bus1.if_valid), 32'd1);
      bus1.if_req = 1'b0; bus1.if_addr = 8'h0C;
      @(negedge clk);
      check("fetch idle valid", 32'(bus1.if_valid), 32'd0);
      check("fetch hold rdata", bus1.if_rdata, 32'hDEADBEEF);

      req4(mk(1, 2'b10, 0, 8'h20, 32'h87654321, 32'h0, 0), 1, "L4 sw");
      req4(mk(0, 2'b10, 0, 8'h20, 32'h0, 32'h87654321, 0), 4, "L4 lw");
      req4(mk(0, 2'b00, 0, 8'h23, 32'h0, 32'hFFFFFF87, 0), 4, "L4 lb");
      req4(mk(0, 2'b01, 1, 8'h22, 32'h0, 32'h00008765, 0), 4, "L4 lhu");
      req4(mk(0, 2'b10, 0, 8'h21, 32'h0, 32'h00000000, 1), 1, "L4 lw misaligned");

      // Reset in the middle of a latency-4 load: the response must be dropped.
      bus4.d_req_valid = 1'b1; bus4.d_req_we = 1'b0; bus4.d_req_size = 2'b10;
      bus4.d_req_unsigned = 1'b0; bus4.d_req_addr = 8'h20;
      @(negedge clk);
      bus4.d_req_valid = 1'b0;
      check("wait ready", 32'(bus4.d_req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst ready", 32'(bus4.d_req_ready), 32'd0);
      check("midrst rsp_valid", 32'(bus4.d_rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst rel ready", 32'(bus4.d_req_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("midrst no rsp %0d", k), 32'(bus4.d_rsp_valid), 32'd0);
      end

      req4(mk(0, 2'b10, 0, 8'h20, 32'h0, 32'h87654321, 0), 4, "L4 readback");
      req1(mk(0, 2'b10, 0, 8'h10, 32'h0, 32'hDEADBEEF, 0), "L1 readback");

      check("sb1 drained", 32'(sb1.size()), 32'd0);
      check("sb4 drained", 32'(sb4.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
